// File: rtl/sprite_render.sv
`default_nettype none
// ============================================================================
// Module      : sprite_render
// Description : Falling-sprite renderer. Scans an external sprite ROM to draw
//               the sprite, erases it with the background colour, then moves
//               it down by a per-drop speed. Respawns at a clamped random x.
//               Optional colour-key transparency: SPRITE_RENDER_TRANSPARENT_EN
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_render #(
    parameter int SPR_W     = 12,
    parameter int SPR_H     = 14,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int COL_W     = 3,
    parameter int SCREEN_W  = 160,
    parameter int Y_LIMIT   = 99,
    parameter int MAX_SPEED = 7,
    parameter int BG_COLOUR = 0
`ifdef SPRITE_RENDER_TRANSPARENT_EN
    ,
    parameter logic [COL_W-1:0] KEY_COLOUR = 3'b111
`endif
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             go,
    input  logic             go_shift,
    input  logic [X_W-1:0]   x_rand,
    output logic [7:0]       rom_addr,
    input  logic [COL_W-1:0] rom_q,
    output logic             plot,
    output logic [X_W-1:0]   x_out,
    output logic [Y_W-1:0]   y_out,
    output logic [COL_W-1:0] colour,
    output logic             done_draw,
    output logic             done_shift,
    output logic             missed
);

    localparam int                 c_SPD_W     = $clog2(MAX_SPEED + 1);
    localparam logic [3:0]         c_PX_LAST   = 4'(SPR_W - 1);
    localparam logic [3:0]         c_PY_LAST   = 4'(SPR_H - 1);
    localparam logic [X_W-1:0]     c_X_MAX     = X_W'(SCREEN_W - SPR_W);
    localparam logic [Y_W-1:0]     c_Y_LIMIT   = Y_W'(Y_LIMIT);
    localparam logic [c_SPD_W-1:0] c_MAX_SPEED = c_SPD_W'(MAX_SPEED);
    localparam logic [c_SPD_W-1:0] c_SPEED_MIN = c_SPD_W'(1);
    localparam logic [COL_W-1:0]   c_BG        = COL_W'(BG_COLOUR);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_DRAW   = 3'd2,
        S_DFLUSH = 3'd3,
        S_WAIT   = 3'd4,
        S_ERASE  = 3'd5,
        S_EFLUSH = 3'd6,
        S_SHIFT  = 3'd7
    } state_t;

    state_t               r_state;
    logic [X_W-1:0]       r_x_pos;
    logic [Y_W-1:0]       r_y_pos;
    logic [c_SPD_W-1:0]   r_speed;
    logic [3:0]           r_px;
    logic [3:0]           r_py;
    logic [7:0]           r_addr;
    logic                 r_flush;

    // Stage 1: scan coordinates aligned with rom_q
    logic                 r_s1_valid;
    logic                 r_s1_erase;
    logic                 r_s1_last;
    logic [3:0]           r_s1_px;
    logic [3:0]           r_s1_py;

    logic                 r_plot;
    logic [X_W-1:0]       r_x_out;
    logic [Y_W-1:0]       r_y_out;
    logic [COL_W-1:0]     r_colour;
    logic                 r_done_draw;
    logic                 r_done_shift;
    logic                 r_missed;

    logic w_scanning;
    logic w_scan_last;
    logic w_at_limit;
    logic w_respawn;
    logic w_transparent;

    assign w_scanning  = (r_state == S_DRAW) || (r_state == S_ERASE);
    assign w_scan_last = (r_px == c_PX_LAST) && (r_py == c_PY_LAST);
    assign w_at_limit  = (r_y_pos >= c_Y_LIMIT);
    assign w_respawn   = (r_y_pos == '0) || w_at_limit;

`ifdef SPRITE_RENDER_TRANSPARENT_EN
    assign w_transparent = !r_s1_erase && (rom_q == KEY_COLOUR);
`else
    assign w_transparent = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_x_pos      <= c_X_MAX;
            r_y_pos      <= '0;
            r_speed      <= c_SPEED_MIN;
            r_px         <= '0;
            r_py         <= '0;
            r_addr       <= '0;
            r_flush      <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_erase   <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s1_px      <= '0;
            r_s1_py      <= '0;
            r_plot       <= 1'b0;
            r_x_out      <= '0;
            r_y_out      <= '0;
            r_colour     <= '0;
            r_done_draw  <= 1'b0;
            r_done_shift <= 1'b0;
            r_missed     <= 1'b0;
        end else begin
            r_s1_valid   <= 1'b0;
            r_s1_last    <= 1'b0;
            r_done_shift <= 1'b0;
            r_missed     <= 1'b0;

            // Raster scan; the address counter tracks py*SPR_W+px
            if (w_scanning) begin
                r_s1_valid <= 1'b1;
                r_s1_px    <= r_px;
                r_s1_py    <= r_py;
                r_s1_erase <= (r_state == S_ERASE);
                r_s1_last  <= w_scan_last;
                if (r_px == c_PX_LAST) begin
                    r_px <= '0;
                    r_py <= w_scan_last ? 4'd0 : r_py + 4'd1;
                end else begin
                    r_px <= r_px + 4'd1;
                end
                r_addr <= w_scan_last ? 8'd0 : r_addr + 8'd1;
            end

            r_plot      <= r_s1_valid && !w_transparent;
            r_done_draw <= r_s1_valid && r_s1_last && !r_s1_erase;
            if (r_s1_valid) begin
                r_x_out  <= r_x_pos + X_W'(r_s1_px);
                r_y_out  <= r_y_pos + Y_W'(r_s1_py);
                r_colour <= r_s1_erase ? c_BG : rom_q;
            end

            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_state  <= S_LOAD;
                        r_missed <= w_at_limit;
                    end
                end
                S_LOAD: begin
                    if (w_respawn) begin
                        r_x_pos <= (x_rand > c_X_MAX) ? c_X_MAX : x_rand;
                        r_y_pos <= '0;
                        r_speed <= (r_speed == c_MAX_SPEED) ? c_SPEED_MIN
                                                            : r_speed + c_SPEED_MIN;
                    end
                    r_state <= S_DRAW;
                end
                S_DRAW: begin
                    if (w_scan_last) begin
                        r_state <= S_DFLUSH;
                        r_flush <= 1'b0;
                    end
                end
                S_DFLUSH: begin
                    if (r_flush) begin
                        r_state <= S_WAIT;
                    end
                    r_flush <= ~r_flush;
                end
                S_WAIT: begin
                    if (go_shift) begin
                        r_state <= S_ERASE;
                    end
                end
                S_ERASE: begin
                    if (w_scan_last) begin
                        r_state <= S_EFLUSH;
                        r_flush <= 1'b0;
                    end
                end
                S_EFLUSH: begin
                    // done_shift is raised on entry so it is visible during SHIFT
                    if (r_flush) begin
                        r_state      <= S_SHIFT;
                        r_done_shift <= 1'b1;
                    end
                    r_flush <= ~r_flush;
                end
                S_SHIFT: begin
                    r_y_pos <= r_y_pos + Y_W'(r_speed);
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rom_addr   = r_addr;
    assign plot       = r_plot;
    assign x_out      = r_x_out;
    assign y_out      = r_y_out;
    assign colour     = r_colour;
    assign done_draw  = r_done_draw;
    assign done_shift = r_done_shift;
    assign missed     = r_missed;

endmodule

`default_nettype wire

// File: tb/tb_sprite_render.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_render
// Description : Directed, table-driven bench for sprite_render (default 12x14
//               instance plus a 2x2 instance for the long speed-wrap run).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_render;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       go = 1'b0;
    logic       go_shift = 1'b0;
    logic [7:0] x_rand = 8'd0;
    logic       sel = 1'b0;
    logic       rom_mode = 1'b0;

    always #5 clk = ~clk;

    // Instance A: default 12x14 sprite
    logic       go_a, gs_a;
    logic [7:0] rom_addr_a;
    logic [2:0] rom_q_a;
    logic       plot_a, dd_a, ds_a, miss_a;
    logic [7:0] x_a;
    logic [6:0] y_a;
    logic [2:0] col_a;

    // Instance B: 2x2 sprite
    logic       go_b, gs_b;
    logic [7:0] rom_addr_b;
    logic [2:0] rom_q_b;
    logic       plot_b, dd_b, ds_b, miss_b;
    logic [7:0] x_b;
    logic [6:0] y_b;
    logic [2:0] col_b;

    assign go_a = go & ~sel;
    assign gs_a = go_shift & ~sel;
    assign go_b = go & sel;
    assign gs_b = go_shift & sel;

    sprite_render u_dut_a (
        .clk(clk), .resetn(resetn), .go(go_a), .go_shift(gs_a), .x_rand(x_rand),
        .rom_addr(rom_addr_a), .rom_q(rom_q_a), .plot(plot_a), .x_out(x_a),
        .y_out(y_a), .colour(col_a), .done_draw(dd_a), .done_shift(ds_a),
        .missed(miss_a)
    );

    sprite_render #(.SPR_W(2), .SPR_H(2)) u_dut_b (
        .clk(clk), .resetn(resetn), .go(go_b), .go_shift(gs_b), .x_rand(x_rand),
        .rom_addr(rom_addr_b), .rom_q(rom_q_b), .plot(plot_b), .x_out(x_b),
        .y_out(y_b), .colour(col_b), .done_draw(dd_b), .done_shift(ds_b),
        .missed(miss_b)
    );

    // Synchronous sprite ROMs: data valid one cycle after the address
    always @(posedge clk) begin
        rom_q_a <= rom_mode ? ((rom_addr_a == 8'd0) ? 3'd0 : 3'd7) : rom_addr_a[2:0];
        rom_q_b <= rom_addr_b[2:0];
    end

    logic       m_plot, m_dd, m_ds, m_miss;
    logic [7:0] m_x;
    logic [6:0] m_y;
    logic [2:0] m_col;
    assign m_plot = sel ? plot_b : plot_a;
    assign m_dd   = sel ? dd_b   : dd_a;
    assign m_ds   = sel ? ds_b   : ds_a;
    assign m_miss = sel ? miss_b : miss_a;
    assign m_x    = sel ? x_b    : x_a;
    assign m_y    = sel ? y_b    : y_a;
    assign m_col  = sel ? col_b  : col_a;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-pass observations
    int n_plot, first_k, last_k, fx, fy, fc, lx, ly, lc;
    int n_dd, n_ds, n_miss, done_k, done_plot, stop_k;

    typedef struct {
        bit erase;
        bit both;
        int xr;
        int n;
        int fk;
        int fx;
        int fy;
        int fc;
        int lx;
        int ly;
        int lc;
        int done_off;
        int miss;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // k counts rising edges after the one that samples go/go_shift (k=0)
    task automatic run_pass(input bit erase, input bit both, input int xr);
        n_plot = 0; first_k = -1; last_k = -1; n_dd = 0; n_ds = 0; n_miss = 0;
        done_k = -1; done_plot = -1; stop_k = -1;
        fx = -1; fy = -1; fc = -1; lx = -1; ly = -1; lc = -1;
        @(negedge clk);
        x_rand = 8'(xr);
        if (erase) begin
            go_shift = 1'b1;
            go = both;
        end else begin
            go = 1'b1;
            go_shift = both;
        end
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            go = 1'b0;
            go_shift = 1'b0;
            if (m_plot) begin
                if (n_plot == 0) begin
                    first_k = k; fx = m_x; fy = m_y; fc = m_col;
                end
                n_plot++;
                last_k = k; lx = m_x; ly = m_y; lc = m_col;
            end
            if (m_dd) begin
                n_dd++;
                done_plot = m_plot;
                if (!erase) done_k = k;
            end
            if (m_ds) begin
                n_ds++;
                if (erase) done_k = k;
            end
            if (m_miss) n_miss++;
            if (stop_k < 0 && ((erase && m_ds) || (!erase && m_dd))) stop_k = k;
            if (stop_k >= 0 && k >= stop_k + 3) break;
        end
        if (stop_k < 0) check("pass_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

    initial begin
        int cnt;
        int hit;
        int my;
        int ms;
        int resp_n;
        int xr;
        bit resp;
        bit exp_miss;
        bit finished;

        //          erase both xr   n   fk fx fy fc lx ly lc off miss
        vecs[0] = '{1'b0, 1'b0, 40, 168, 3, 40, 0, 0, 51, 13, 7, 0, 0};
        vecs[1] = '{1'b1, 1'b1,  0, 168, 2, 40, 0, 0, 51, 13, 0, 1, 0};
        vecs[2] = '{1'b0, 1'b1, 90, 168, 3, 40, 2, 0, 51, 15, 7, 0, 0};
        vecs[3] = '{1'b1, 1'b0,  0, 168, 2, 40, 2, 0, 51, 15, 0, 1, 0};
        vecs[4] = '{1'b0, 1'b0,  7, 168, 3, 40, 4, 0, 51, 17, 7, 0, 0};
        vecs[5] = '{1'b1, 1'b0,  0, 168, 2, 40, 4, 0, 51, 17, 0, 1, 0};

        do_reset();
        @(negedge clk);
        check("rst_plot", plot_a, 0);
        check("rst_x_out", x_a, 0);
        check("rst_y_out", y_a, 0);
        check("rst_colour", col_a, 0);
        check("rst_rom_addr", rom_addr_a, 0);
        check("rst_pulses", {dd_a, ds_a, miss_a}, 0);

        for (int i = 0; i < 6; i++) begin
            run_pass(vecs[i].erase, vecs[i].both, vecs[i].xr);
            check($sformatf("v%0d_nplot", i), n_plot, vecs[i].n);
            check($sformatf("v%0d_first_k", i), first_k, vecs[i].fk);
            check($sformatf("v%0d_first_x", i), fx, vecs[i].fx);
            check($sformatf("v%0d_first_y", i), fy, vecs[i].fy);
            check($sformatf("v%0d_first_col", i), fc, vecs[i].fc);
            check($sformatf("v%0d_last_x", i), lx, vecs[i].lx);
            check($sformatf("v%0d_last_y", i), ly, vecs[i].ly);
            check($sformatf("v%0d_last_col", i), lc, vecs[i].lc);
            check($sformatf("v%0d_done_off", i), done_k - last_k, vecs[i].done_off);
            check($sformatf("v%0d_n_done_draw", i), n_dd, vecs[i].erase ? 0 : 1);
            check($sformatf("v%0d_n_done_shift", i), n_ds, vecs[i].erase ? 1 : 0);
            check($sformatf("v%0d_missed", i), n_miss, vecs[i].miss);
        end

        // go must be ignored while waiting for go_shift
        run_pass(1'b0, 1'b0, 0);
        check("wait_draw_y", fy, 6);
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (plot_a) cnt++;
        end
        check("wait_go_ignored", cnt, 0);
        run_pass(1'b1, 1'b0, 0);
        check("wait_erase_nplot", n_plot, 168);
        check("wait_erase_y", fy, 6);

        // Spawn x clamps to SCREEN_W-SPR_W
        do_reset();
        run_pass(1'b0, 1'b0, 200);
        check("clamp_first_x", fx, 148);
        check("clamp_last_x", lx, 159);
        check("clamp_nplot", n_plot, 168);

        // Asynchronous reset in the middle of a draw
        do_reset();
        @(negedge clk);
        x_rand = 8'd40;
        go = 1'b1;
        cnt = 0;
        hit = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            go = 1'b0;
            if (plot_a) cnt++;
            if (cnt == 50) begin
                hit = 1;
                break;
            end
        end
        check("mid_rst_reached", hit, 1);
        resetn = 1'b0;
        #1;
        check("mid_rst_plot", plot_a, 0);
        check("mid_rst_x", x_a, 0);
        check("mid_rst_y", y_a, 0);
        check("mid_rst_rom_addr", rom_addr_a, 0);
        @(negedge clk);
        resetn = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (plot_a) cnt++;
        end
        check("mid_rst_quiet", cnt, 0);
        run_pass(1'b0, 1'b0, 40);
        check("restart_nplot", n_plot, 168);
        check("restart_first_k", first_k, 3);
        check("restart_first_x", fx, 40);
        check("restart_first_y", fy, 0);

`ifdef SPRITE_RENDER_TRANSPARENT_EN
        rom_mode = 1'b1;
        do_reset();
        run_pass(1'b0, 1'b0, 40);
        check("key_draw_nplot", n_plot, 1);
        check("key_first_x", fx, 40);
        check("key_done_draw", n_dd, 1);
        check("key_done_plot", done_plot, 0);
        run_pass(1'b1, 1'b0, 0);
        check("key_erase_nplot", n_plot, 168);
        rom_mode = 1'b0;
`endif

        // Long descent on the 2x2 instance: missed pulses and speed wrap
        sel = 1'b1;
        do_reset();
        my = 0;
        ms = 1;
        resp_n = 0;
        finished = 1'b0;
        for (int it = 0; it < 400 && !finished; it++) begin
            xr = (it * 37) % 256;
            resp = (my == 0) || (my >= 99);
            exp_miss = (my >= 99);
            if (resp) begin
                my = 0;
                ms = (ms == 7) ? 1 : ms + 1;
                resp_n++;
            end
            run_pass(1'b0, 1'b0, xr);
            check("b_nplot", n_plot, 4);
            check("b_first_y", fy, my);
            check("b_missed", n_miss, exp_miss ? 1 : 0);
            if (resp) check("b_spawn_x", fx, (xr > 158) ? 158 : xr);
            if (resp_n == 7 && !resp) begin
                check("b_wrap_step", fy, 1);
                finished = 1'b1;
            end
            run_pass(1'b1, 1'b0, 0);
            check("b_erase_nplot", n_plot, 4);
            my = (my + ms) % 128;
        end
        check("b_wrap_reached", finished, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
